operand_entry_reg: RTL and testbench
====================================

Name: operand_entry_reg

Overview:
- Multi-digit operand entry register for the keypad calculator datapath. It is the successor to the single-digit operand-A/B latch.
- Accumulates decimal key presses into a DIGITS-wide BCD buffer and a binary value, with backspace, clear and commit.
- One instance is used per operand. The calculator FSM drives commit and clear_op and reads value once done is set.

Parameters:
- DIGITS, 3, maximum number of decimal digits held (1..6).
- KEY_W, 5, width of the keypad code bus; codes 0..9 are digits.
- VAL_W, 10, width of the binary value output; must satisfy 2^VAL_W > 10^DIGITS-1.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- key  input  KEY_W  keypad code; 0..9 are digits; 5'b11111 means no key.
- press  input  1  key strobe level; the block detects its rising edge internally.
- backspace  input  1  level; its rising edge removes the last digit.
- commit  input  1  level; its rising edge finalises the operand.
- clear_op  input  1  level; while high, the operand is cleared on every cycle (replaces the old secondNum clear).
- enable  input  1  active-high; when low, press, backspace and commit edges are ignored silently.
- bcd  output  4*DIGITS  BCD digits; the least significant digit is in [3:0].
- value  output  VAL_W  binary equivalent of bcd; combinational from the bcd register.
- digit_count  output  $clog2(DIGITS+1)  number of digits entered.
- loaded  output  1  high when digit_count > 0.
- full  output  1  high when digit_count == DIGITS.
- done  output  1  high in state LOCKED.
- rejected  output  1  single-cycle pulse when an input edge is refused.

Behaviour:
- Reset (reset=1 at a clock edge):
  - state=IDLE, bcd=0, digit_count=0, done=0, rejected=0.
  - Edge-detect registers are loaded with the current inputs, so a button held through reset does not produce an edge.
  - Reset mid-entry discards all digits.
- Edge detection: press_q, bs_q and commit_q are registered every cycle. An edge is signal & ~signal_q. The first edge is acted on in the same cycle it is seen; outputs update at the next clock.
- States: IDLE (count 0), ENTRY (1..DIGITS-1), FULL (count DIGITS), LOCKED (committed).
- Priority at each clock, highest first:
  1. reset
  2. clear_op
  3. commit edge
  4. backspace edge
  5. press edge
  Only one action is taken per cycle. A lower-priority edge that occurs in the same cycle as a higher one is dropped and pulses rejected; the press edge is not replayed.
- clear_op: bcd=0, count=0, state=IDLE, done=0. Pending edges in that cycle are ignored with no rejected pulse.
- Digit accept (press edge, key<=9, state IDLE or ENTRY, enable=1):
  - bcd = {bcd[4*DIGITS-5:0], key[3:0]}.
  - count += 1.
  - State goes to ENTRY, or to FULL when the new count equals DIGITS.
- Digit reject: press edge with key>9 (including 5'b11111), or with state FULL or LOCKED -> rejected=1 for one cycle; no state change.
- Backspace edge:
  - In ENTRY or FULL: bcd = {4'h0, bcd[4*DIGITS-1:4]}; count -= 1; state is recomputed from the new count.
  - In IDLE or LOCKED: rejected=1; no change.
- Commit edge:
  - In ENTRY or FULL: state=LOCKED, done=1; bcd and value are frozen.
  - In IDLE: rejected=1.
  - In LOCKED: ignored, no pulse.
- LOCKED is left only via clear_op or reset.
- value: sum over i of bcd digit i × 10^i, zero-extended or truncated to VAL_W. It is valid in the same cycle as bcd.
- enable=0: edge registers still update, so an edge that rises while disabled is lost rather than replayed later. clear_op is still honoured.

Decomposition:
- Shared package calc_pkg:
  - KEY_NONE = 5'b11111.
  - KEY_MAX_DIGIT = 9.
  - State enum entry_state_t {IDLE, ENTRY, FULL, LOCKED}.
- Sub-module bcd_to_bin: purely combinational DIGITS→VAL_W converter (multiply-accumulate by 10). It is reused by the display path.

Test Plan (DIGITS=3, VAL_W=10):
- Keys 4,0,7, each with a one-cycle press pulse -> bcd=12'h407, value=407, count=3, full=1, loaded=1.
- From 407, a further press with key=2 -> rejected pulse, bcd stays 12'h407. Then backspace -> bcd=12'h040, value=40, count=2, full=0.
- Press held high for 10 cycles with key=5 -> exactly one digit accepted (bcd=12'h005). Press with key=5'b11111 -> rejected, count unchanged.
- Enter 3,1 then commit -> done=1, value=31. Further press/backspace edges -> rejected, value stays 31. clear_op -> bcd=0, done=0, state IDLE.
- Same-cycle edges with digits 9 then 8 entered: press edge (key=6) together with backspace edge -> bcd=12'h009, rejected=1. Commit together with backspace -> LOCKED, value=9.
- Reset asserted mid-entry (after 2 digits) with press held high -> all outputs zero after reset; no digit accepted until press falls and rises again.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator datapath.
package calc_pkg;

  // Keypad code meaning "no key pressed".
  localparam logic [4:0] KEY_NONE = 5'b11111;

  // Highest keypad code that is a decimal digit.
  localparam int KEY_MAX_DIGIT = 9;

  // Operand entry states: empty, partially filled, full, committed.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    FULL   = 2'd2,
    LOCKED = 2'd3
  } entry_state_t;

endpackage

// File: rtl/bcd_to_bin.sv
// Combinational BCD to binary converter, most significant digit first,
// multiply-accumulate by ten. Shared with the display path.
module bcd_to_bin #(
  parameter int DIGITS = 3,
  parameter int VAL_W  = 10
) (
  input  logic [4*DIGITS-1:0] bcd,
  output logic [VAL_W-1:0]    value
);

  // Horner evaluation; result wraps to VAL_W bits if it does not fit.
  always_comb begin
    logic [VAL_W-1:0] acc;
    acc = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc = (acc * VAL_W'(10)) + VAL_W'(bcd[4*i +: 4]);
    end
    value = acc;
  end

endmodule

// File: rtl/operand_entry_reg.sv
// Multi-digit operand entry register: accumulates keypad digits into a BCD
// buffer with backspace, clear and commit, and exposes the binary value.
module operand_entry_reg
  import calc_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int KEY_W  = 5,
  parameter int VAL_W  = 10
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [KEY_W-1:0]             key,
  input  logic                         press,
  input  logic                         backspace,
  input  logic                         commit,
  input  logic                         clear_op,
  input  logic                         enable,
  output logic [4*DIGITS-1:0]          bcd,
  output logic [VAL_W-1:0]             value,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         loaded,
  output logic                         full,
  output logic                         done,
  output logic                         rejected
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  entry_state_t  state, state_n;
  logic [BW-1:0] bcd_r, bcd_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          rej_r, rej_n;
  logic          press_q, bs_q, commit_q;
  logic          press_e, bs_e, commit_e;
  logic          key_is_digit;

  // Edges only count while enabled; a disabled edge is consumed by the
  // edge registers below and never replayed.
  assign press_e  = enable & press     & ~press_q;
  assign bs_e     = enable & backspace & ~bs_q;
  assign commit_e = enable & commit    & ~commit_q;

  assign key_is_digit = (key != KEY_W'(KEY_NONE)) && (key <= KEY_W'(KEY_MAX_DIGIT));

  // Next-state selection: clear_op, then commit, backspace, press; any
  // lower-priority edge seen alongside the chosen action is refused.
  always_comb begin
    state_n = state;
    bcd_n   = bcd_r;
    cnt_n   = cnt;
    rej_n   = 1'b0;
    if (clear_op) begin
      state_n = IDLE;
      bcd_n   = '0;
      cnt_n   = '0;
    end else if (commit_e) begin
      case (state)
        ENTRY, FULL: state_n = LOCKED;
        IDLE:        rej_n   = 1'b1;
        default:     ;
      endcase
      if (bs_e || press_e) rej_n = 1'b1;
    end else if (bs_e) begin
      if (state == ENTRY || state == FULL) begin
        bcd_n   = bcd_r >> 4;
        cnt_n   = cnt - CW'(1);
        state_n = (cnt == CW'(1)) ? IDLE : ENTRY;
      end else begin
        rej_n = 1'b1;
      end
      if (press_e) rej_n = 1'b1;
    end else if (press_e) begin
      if (key_is_digit && (state == IDLE || state == ENTRY)) begin
        bcd_n   = (bcd_r << 4) | BW'(key[3:0]);
        cnt_n   = cnt + CW'(1);
        state_n = (cnt + CW'(1) == CW'(DIGITS)) ? FULL : ENTRY;
      end else begin
        rej_n = 1'b1;
      end
    end
  end

  // Edge registers track the inputs every cycle, reset included, so a
  // button held through reset yields no edge afterwards.
  always_ff @(posedge clock) begin
    press_q  <= press;
    bs_q     <= backspace;
    commit_q <= commit;
  end

  // Operand state and refusal pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      bcd_r <= '0;
      cnt   <= '0;
      rej_r <= 1'b0;
    end else begin
      state <= state_n;
      bcd_r <= bcd_n;
      cnt   <= cnt_n;
      rej_r <= rej_n;
    end
  end

  bcd_to_bin #(
    .DIGITS (DIGITS),
    .VAL_W  (VAL_W)
  ) u_bcd_to_bin (
    .bcd   (bcd_r),
    .value (value)
  );

  assign bcd         = bcd_r;
  assign digit_count = cnt;
  assign loaded      = (cnt != '0);
  assign full        = (cnt == CW'(DIGITS));
  assign done        = (state == LOCKED);
  assign rejected    = rej_r;

endmodule

// File: tb/tb_operand_entry_reg.sv
// Directed bench for operand_entry_reg (DIGITS=3, VAL_W=10). Each vector
// pushes its hand-computed expected outputs into a queue; a monitor pops
// and compares them on the falling edge after the clock that applies them.
module tb_operand_entry_reg;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  key;
  logic        press, backspace, commit, clear_op, enable;
  logic [11:0] bcd;
  logic [9:0]  value;
  logic [1:0]  digit_count;
  logic        loaded, full, done, rejected;

  operand_entry_reg #(
    .DIGITS (3),
    .KEY_W  (5),
    .VAL_W  (10)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key         (key),
    .press       (press),
    .backspace   (backspace),
    .commit      (commit),
    .clear_op    (clear_op),
    .enable      (enable),
    .bcd         (bcd),
    .value       (value),
    .digit_count (digit_count),
    .loaded      (loaded),
    .full        (full),
    .done        (done),
    .rejected    (rejected)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          tag;
    int          idx;
    logic [27:0] exp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   vec_id = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clock) begin
    logic [27:0] act;
    act = {bcd, value, digit_count, loaded, full, done, rejected};
    while (q.size() > 0 && q[0].tag <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (e.tag != cyc) begin
        n_bad++;
        $display("FAIL vec%0d stale expectation (tag %0d, cycle %0d)", e.idx, e.tag, cyc);
      end else if (act !== e.exp) begin
        n_bad++;
        $display("FAIL vec%0d {bcd,value,cnt,ld,full,done,rej}: got bcd=%h val=%0d cnt=%0d ld=%b full=%b done=%b rej=%b, want bcd=%h val=%0d cnt=%0d ld=%b full=%b done=%b rej=%b",
                 e.idx, act[27:16], act[15:6], act[5:4], act[3], act[2], act[1], act[0],
                 e.exp[27:16], e.exp[15:6], e.exp[5:4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the clock.
  task automatic v(input logic rs, input logic pr, input logic [4:0] k, input logic bs,
                   input logic cm, input logic cl, input logic en,
                   input logic [11:0] eb, input int ev, input int ec,
                   input logic ed, input logic er);
    exp_t e;
    reset = rs; press = pr; key = k; backspace = bs;
    commit = cm; clear_op = cl; enable = en;
    e.tag = cyc + 1;
    e.idx = vec_id++;
    e.exp = {eb, 10'(ev), 2'(ec), (ec != 0), (ec == 3), ed, er};
    q.push_back(e);
    @(posedge clock); #1;
  endtask

  localparam logic [4:0] NK = 5'b11111;

  initial begin
    reset = 1'b1; press = 0; key = NK; backspace = 0;
    commit = 0; clear_op = 0; enable = 1;
    @(posedge clock); #1;
    //  rs pr key bs cm cl en  bcd     val cnt done rej
    v(1, 0, NK, 0, 0, 0, 1, 12'h000,   0, 0, 0, 0);
    v(0, 0, NK, 0, 0, 0, 1, 12'h000,   0, 0, 0, 0);
    // Keys 4,0,7
    v(0, 1, 4,  0, 0, 0, 1, 12'h004,   4, 1, 0, 0);
    v(0, 0, 4,  0, 0, 0, 1, 12'h004,   4, 1, 0, 0);
    v(0, 1, 0,  0, 0, 0, 1, 12'h040,  40, 2, 0, 0);
    v(0, 0, 0,  0, 0, 0, 1, 12'h040,  40, 2, 0, 0);
    v(0, 1, 7,  0, 0, 0, 1, 12'h407, 407, 3, 0, 0);
    v(0, 0, 7,  0, 0, 0, 1, 12'h407, 407, 3, 0, 0);
    // Press while full, then backspace
    v(0, 1, 2,  0, 0, 0, 1, 12'h407, 407, 3, 0, 1);
    v(0, 0, 2,  0, 0, 0, 1, 12'h407, 407, 3, 0, 0);
    v(0, 0, NK, 1, 0, 0, 1, 12'h040,  40, 2, 0, 0);
    v(0, 0, NK, 0, 0, 0, 1, 12'h040,  40, 2, 0, 0);
    v(0, 0, NK, 0, 0, 1, 1, 12'h000,   0, 0, 0, 0);
    v(0, 0, NK, 0, 0, 0, 1, 12'h000,   0, 0, 0, 0);
    // Press held for 10 cycles accepts one digit
    v(0, 1, 5,  0, 0, 0, 1, 12'h005,   5, 1, 0, 0);
    for (int i = 0; i < 9; i++) v(0, 1, 5, 0, 0, 0, 1, 12'h005, 5, 1, 0, 0);
    v(0, 0, 5,  0, 0, 0, 1, 12'h005,   5, 1, 0, 0);
    // No-key code is refused
    v(0, 1, NK, 0, 0, 0, 1, 12'h005,   5, 1, 0, 1);
    v(0, 0, NK, 0, 0, 0, 1, 12'h005,   5, 1, 0, 0);
    v(0, 0, NK, 0, 0, 1, 1, 12'h000,   0, 0, 0, 0);
    v(0, 0, NK, 0, 0, 0, 1, 12'h000,   0, 0, 0, 0);
    // Enter 3,1 and commit; edges afterwards refused
    v(0, 1, 3,  0, 0, 0, 1, 12'h003,   3, 1, 0, 0);
    v(0, 0, 3,  0, 0, 0, 1, 12'h003,   3, 1, 0, 0);
    v(0, 1, 1,  0, 0, 0, 1, 12'h031,  31, 2, 0, 0);
    v(0, 0, 1,  0, 0, 0, 1, 12'h031,  31, 2, 0, 0);
    v(0, 0, NK, 0, 1, 0, 1, 12'h031,  31, 2, 1, 0);
    v(0, 0, NK, 0, 0, 0, 1, 12'h031,  31, 2, 1, 0);
    v(0, 1, 2,  0, 0, 0, 1, 12'h031,  31, 2, 1, 1);
    v(0, 0, 2,  0, 0, 0, 1, 12'h031,  31, 2, 1, 0);
    v(0, 0, NK, 1, 0, 0, 1, 12'h031,  31, 2, 1, 1);
    v(0, 0, NK, 0, 0, 0, 1, 12'h031,  31, 2, 1, 0);
    v(0, 0, NK, 0, 1, 0, 1, 12'h031,  31, 2, 1, 0);
    v(0, 0, NK, 0, 0, 0, 1, 12'h031,  31, 2, 1, 0);
    v(0, 0, NK, 0, 0, 1, 1, 12'h000,   0, 0, 0, 0);
    v(0, 0, NK, 0, 0, 0, 1, 12'h000,   0, 0, 0, 0);
    // 9,8 then same-cycle press+backspace, then commit+backspace
    v(0, 1, 9,  0, 0, 0, 1, 12'h009,   9, 1, 0, 0);
    v(0, 0, 9,  0, 0, 0, 1, 12'h009,   9, 1, 0, 0);
    v(0, 1, 8,  0, 0, 0, 1, 12'h098,  98, 2, 0, 0);
    v(0, 0, 8,  0, 0, 0, 1, 12'h098,  98, 2, 0, 0);
    v(0, 1, 6,  1, 0, 0, 1, 12'h009,   9, 1, 0, 1);
    v(0, 0, 6,  0, 0, 0, 1, 12'h009,   9, 1, 0, 0);
    v(0, 0, NK, 1, 1, 0, 1, 12'h009,   9, 1, 1, 1);
    v(0, 0, NK, 0, 0, 0, 1, 12'h009,   9, 1, 1, 0);
    // Edge while disabled is lost
    v(0, 0, NK, 0, 0, 1, 1, 12'h000,   0, 0, 0, 0);
    v(0, 0, NK, 0, 0, 0, 1, 12'h000,   0, 0, 0, 0);
    v(0, 1, 3,  0, 0, 0, 0, 12'h000,   0, 0, 0, 0);
    v(0, 1, 3,  0, 0, 0, 1, 12'h000,   0, 0, 0, 0);
    v(0, 0, 3,  0, 0, 0, 1, 12'h000,   0, 0, 0, 0);
    v(0, 1, 3,  0, 0, 0, 1, 12'h003,   3, 1, 0, 0);
    v(0, 0, 3,  0, 0, 0, 1, 12'h003,   3, 1, 0, 0);
    // Reset mid-entry with press held
    v(0, 1, 2,  0, 0, 0, 1, 12'h032,  32, 2, 0, 0);
    v(0, 0, 2,  0, 0, 0, 1, 12'h032,  32, 2, 0, 0);
    v(1, 1, 4,  0, 0, 0, 1, 12'h000,   0, 0, 0, 0);
    v(0, 1, 4,  0, 0, 0, 1, 12'h000,   0, 0, 0, 0);
    v(0, 1, 4,  0, 0, 0, 1, 12'h000,   0, 0, 0, 0);
    v(0, 0, 4,  0, 0, 0, 1, 12'h000,   0, 0, 0, 0);
    v(0, 1, 4,  0, 0, 0, 1, 12'h004,   4, 1, 0, 0);
    v(0, 0, 4,  0, 0, 0, 1, 12'h004,   4, 1, 0, 0);
    // Commit and backspace while empty; clear swallows a pending press
    v(0, 0, NK, 0, 0, 1, 1, 12'h000,   0, 0, 0, 0);
    v(0, 0, NK, 0, 0, 0, 1, 12'h000,   0, 0, 0, 0);
    v(0, 0, NK, 0, 1, 0, 1, 12'h000,   0, 0, 0, 1);
    v(0, 0, NK, 0, 0, 0, 1, 12'h000,   0, 0, 0, 0);
    v(0, 0, NK, 1, 0, 0, 1, 12'h000,   0, 0, 0, 1);
    v(0, 0, NK, 0, 0, 0, 1, 12'h000,   0, 0, 0, 0);
    v(0, 1, 1,  0, 0, 1, 1, 12'h000,   0, 0, 0, 0);
    v(0, 0, 1,  0, 0, 0, 1, 12'h000,   0, 0, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
    @(negedge clock); #1;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
